// File: rtl/mp_cond_sub.sv
// Bit-serial-by-slice conditional subtract: result = (x >= M) ? x - M : x, one slice per cycle.
// Optional overflow flag output 'err' is enabled by defining MP_COND_SUB_ERR_EN.
module mp_cond_sub #(
  parameter int SLICE_W = 206,
  parameter int SLICES  = 5
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [1027:0] in_x,
  input  logic [1026:0] in_m,
  output logic [1026:0] result,
  output logic          done,
  output logic          busy
`ifdef MP_COND_SUB_ERR_EN
  ,
  output logic          err
`endif
);

  localparam int W     = SLICE_W * SLICES;
  localparam int CNT_W = (SLICES > 1) ? $clog2(SLICES) : 1;
`ifdef MP_COND_SUB_ERR_EN
  localparam int KEEP_W = 1028;
`else
  localparam int KEEP_W = 1027;
`endif

  typedef enum logic [1:0] {IDLE, SUB, SEL, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                carry;
  logic [W-1:0]        x_shift;
  logic [W-1:0]        m_shift;
  logic [W-1:0]        diff;
  logic [KEEP_W-1:0]   x_keep;
  logic [SLICE_W:0]    slice_sum;
  logic                last_slice;

  // x - M as x + ~M + 1; the carry register starts at 1 and ripples between slices.
  assign slice_sum  = {1'b0, x_shift[SLICE_W-1:0]}
                    + {1'b0, ~m_shift[SLICE_W-1:0]}
                    + {{SLICE_W{1'b0}}, carry};
  assign last_slice = (cnt == CNT_W'(SLICES - 1));
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SUB;
      SUB:     if (last_slice) state_nxt = SEL;
      SEL:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Difference slices enter at the top so slice 0 ends up at the LSB after the last shift.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt     <= '0;
      carry   <= 1'b0;
      x_shift <= '0;
      m_shift <= '0;
      diff    <= '0;
      x_keep  <= '0;
      result  <= '0;
      done    <= 1'b0;
`ifdef MP_COND_SUB_ERR_EN
      err     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_shift <= W'(in_x);
            m_shift <= W'(in_m);
            x_keep  <= in_x[KEEP_W-1:0];
            cnt     <= '0;
            carry   <= 1'b1;
          end
        end
        SUB: begin
          diff    <= {slice_sum[SLICE_W-1:0], diff[W-1:SLICE_W]};
          carry   <= slice_sum[SLICE_W];
          x_shift <= x_shift >> SLICE_W;
          m_shift <= m_shift >> SLICE_W;
          cnt     <= cnt + CNT_W'(1);
        end
        SEL: begin
          result <= carry ? diff[1026:0] : x_keep[1026:0];
          done   <= 1'b1;
`ifdef MP_COND_SUB_ERR_EN
          err    <= carry ? diff[1027] : x_keep[1027];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_cond_sub.sv
// Directed self-checking bench for mp_cond_sub; define MP_COND_SUB_ERR_EN to also cover err.
module tb_mp_cond_sub;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [1027:0] in_x = '0;
  logic [1026:0] in_m = '0;
  logic [1026:0] result;
  logic          done;
  logic          busy;
`ifdef MP_COND_SUB_ERR_EN
  logic          err;
`endif

  int errors = 0;
  int checks = 0;
  logic [1027:0] one = 1028'd1;

  mp_cond_sub dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .in_x   (in_x),
    .in_m   (in_m),
    .result (result),
    .done   (done),
    .busy   (busy)
`ifdef MP_COND_SUB_ERR_EN
    ,
    .err    (err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Pulses start for one edge and counts edges until done (lat = -1 if it never comes).
  task automatic run_op(input logic [1027:0] x, input logic [1026:0] m, output int lat);
    in_x  = x;
    in_m  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (result !== '0) begin errors++; $display("[TB] FAIL reset_result: got %0h want 0", result[127:0]); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    in_x  = 1028'd10;
    in_m  = 1027'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_e0: got %b want 1", busy); end
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      checks++; if (done !== (k == 6)) begin errors++; $display("[TB] FAIL basic_done_e%0d: got %b want %b", k, done, (k == 6)); end
      checks++; if (busy !== (k <= 6)) begin errors++; $display("[TB] FAIL basic_busy_e%0d: got %b want %b", k, busy, (k <= 6)); end
      if (k == 5) begin
        checks++; if (result !== '0) begin errors++; $display("[TB] FAIL basic_hold_e5: got %0h want 0", result[127:0]); end
      end
    end
    checks++; if (result !== 1027'd3) begin errors++; $display("[TB] FAIL basic_result: got %0h want 3", result[127:0]); end
  endtask

  // Shared shape for the single-operation vectors: latency 6 and the hand-computed result.
  task automatic test_vector(input string name, input logic [1027:0] x, input logic [1026:0] m,
                             input logic [1026:0] exp);
    int lat;
    run_op(x, m, lat);
    checks++; if (lat !== 6) begin errors++; $display("[TB] FAIL %s_latency: got %0d want 6", name, lat); end
    checks++;
    if (result !== exp) begin
      errors++;
      $display("[TB] FAIL %s_result: got hi=%0h lo=%0h want hi=%0h lo=%0h",
               name, result[1026:896], result[255:0], exp[1026:896], exp[255:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_less_than();
    test_vector("less", 1028'd5, 1027'd7, 1027'd5);
  endtask

  task automatic test_equal();
    logic [1027:0] x;
    x = (one << 1026) + 1028'd1;
    test_vector("equal", x, x[1026:0], '0);
  endtask

  task automatic test_slice_borrow();
    logic [1027:0] x;
    logic [1026:0] e;
    x = one << 206;
    e = '1;
    e = e >> (1027 - 206);
    test_vector("borrow206", x, 1027'd1, e);
  endtask

  task automatic test_top_boundary();
    logic [1027:0] x;
    logic [1027:0] m;
    x = one << 1026;
    m = x - 1028'd1;
    test_vector("top", x, m[1026:0], 1027'd1);
  endtask

  task automatic test_m_zero();
    logic [1027:0] x;
    x = (one << 1026) | 1028'h1234_5678_9abc;
    test_vector("mzero", x, '0, x[1026:0]);
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    int done_edge = -1;
    in_x  = 1028'd100;
    in_m  = 1027'd30;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 2 || k == 4) begin
        start = 1'b1;
        in_x  = 1028'd50 + 1028'(k);
        in_m  = 1027'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) done_edge = k;
      end
    end
    checks++; if (done_edge !== 6) begin errors++; $display("[TB] FAIL b2b_done_edge: got %0d want 6", done_edge); end
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d want 1", done_cnt); end
    checks++; if (result !== 1027'd70) begin errors++; $display("[TB] FAIL b2b_result: got %0h want 46", result[127:0]); end
  endtask

  task automatic test_reset_mid_op();
    int done_cnt = 0;
    int lat;
    in_x  = 1028'd20;
    in_m  = 1027'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (result !== '0) begin errors++; $display("[TB] FAIL midrst_result: got %0h want 0", result[127:0]); end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt !== 0) begin errors++; $display("[TB] FAIL midrst_no_done: got %0d pulses want 0", done_cnt); end
    run_op(1028'd9, 1027'd4, lat);
    checks++; if (lat !== 6) begin errors++; $display("[TB] FAIL midrst_next_latency: got %0d want 6", lat); end
    checks++; if (result !== 1027'd5) begin errors++; $display("[TB] FAIL midrst_next_result: got %0h want 5", result[127:0]); end
    @(posedge clk); #1;
  endtask

`ifdef MP_COND_SUB_ERR_EN
  task automatic test_err();
    int lat;
    run_op((one << 1027) + 1028'd5, 1027'd1, lat);
    checks++; if (lat !== 6) begin errors++; $display("[TB] FAIL err_latency: got %0d want 6", lat); end
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_set: got %b want 1", err); end
    checks++; if (result !== 1027'd4) begin errors++; $display("[TB] FAIL err_result: got %0h want 4", result[127:0]); end
    @(posedge clk); #1;
    run_op(1028'd10, 1027'd7, lat);
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_clear: got %b want 0", err); end
    checks++; if (result !== 1027'd3) begin errors++; $display("[TB] FAIL err_clear_result: got %0h want 3", result[127:0]); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    $display("[TB] mp_cond_sub directed test start");
    test_reset();
    test_basic();
    @(posedge clk); #1;
    test_less_than();
    test_equal();
    test_slice_borrow();
    test_top_boundary();
    test_m_zero();
    test_back_to_back();
    test_reset_mid_op();
`ifdef MP_COND_SUB_ERR_EN
    test_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
